// File: rtl/flit_pkt_tracker.sv
// Per-VC packet-boundary tracker: a registered pass-through stage that marks sop/eop,
// checks id/req consistency within a packet and counts completed packets per VC.

module flit_vc_state #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [1:0]       id,
  input  logic [4:0]       req,
  input  logic [3:0]       hdr_fmt,
  input  logic [7:0]       hdr_total,
  output logic             sop,
  output logic             eop,
  output logic             err_seq,
  output logic [3:0]       fmt,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic {IDLE, BODY} state_t;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [3:0] fmt_q;
  logic [1:0] id_q;
  logic [4:0] req_q;

  // Flags describe the flit currently offered on this VC; they only matter when hit.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sop     = 1'b0;
    eop     = 1'b0;
    err_seq = 1'b0;
    fmt     = fmt_q;
    case (state_q)
      IDLE: begin
        sop = 1'b1;
        fmt = hdr_fmt;
        eop = (hdr_total == 8'd1);
        if (hit && hdr_total != 8'd1) begin
          state_d = BODY;
          rem_d   = hdr_total - 8'd1;
        end
      end
      BODY: begin
        eop     = (rem_q == 8'd1);
        err_seq = (id != id_q) || (req != req_q);
        if (hit) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      fmt_q   <= '0;
      id_q    <= '0;
      req_q   <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (hit && state_q == IDLE) begin
        fmt_q <= hdr_fmt;
        id_q  <= id;
        req_q <= req;
      end
      if (hit && eop) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module flit_pkt_tracker #(
  parameter int NUM_VCS = 2,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16,
  parameter int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VC_W-1:0]          in_vc,
  input  logic [1:0]               in_id,
  input  logic [4:0]               in_req,
  input  logic [WORD_W-1:0]        in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VC_W-1:0]          out_vc,
  output logic [1:0]               out_id,
  output logic [4:0]               out_req,
  output logic [WORD_W-1:0]        out_payload,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [3:0]               out_fmt,
  output logic                     err_fmt,
  output logic                     err_seq,
  output logic [NUM_VCS*CNT_W-1:0] pkt_cnt
);
  localparam int NV2 = 1 << VC_W;

  localparam logic [3:0] FMT_LONG_READ   = 4'd0;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'd1;
  localparam logic [3:0] FMT_MEM_RESP    = 4'd2;
  localparam logic [3:0] FMT_MSG         = 4'd3;
  localparam logic [3:0] FMT_SWITCH_CFG  = 4'd4;
  localparam logic [3:0] FMT_SHORT_READ  = 4'd5;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'd6;

  if (WORD_W < 32) begin : g_bad_width
    $error("flit_pkt_tracker: WORD_W must be >= 32");
  end

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [1:0]        id;
    logic [4:0]        req;
    logic [WORD_W-1:0] payload;
    logic              sop;
    logic              eop;
    logic [3:0]        fmt;
    logic              err_fmt;
    logic              err_seq;
  } out_flit_t;

  logic       xfer;
  logic [3:0] hdr_fmt;
  logic [7:0] len7, len4, hdr_total;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign hdr_fmt  = in_payload[31:28];

  // A zero length field encodes the maximum length of that field.
  assign len7 = (in_payload[6:0] == 7'd0) ? 8'd128 : {1'b0, in_payload[6:0]};
  assign len4 = (in_payload[3:0] == 4'd0) ? 8'd16  : {4'b0, in_payload[3:0]};

  always_comb begin
    hdr_total = 8'd1;
    case (hdr_fmt)
      FMT_LONG_READ:   hdr_total = 8'd2;
      FMT_LONG_WRITE:  hdr_total = 8'd2 + len7;
      FMT_MEM_RESP,
      FMT_MSG:         hdr_total = 8'd1 + len7;
      FMT_SWITCH_CFG,
      FMT_SHORT_READ:  hdr_total = 8'd1;
      FMT_SHORT_WRITE: hdr_total = 8'd1 + len4;
      default:         hdr_total = 8'd1;
    endcase
  end

  logic [NV2-1:0]      vc_sop, vc_eop, vc_err_seq;
  logic [NV2-1:0][3:0] vc_fmt;

  for (genvar v = 0; v < NV2; v++) begin : g_vc
    if (v < NUM_VCS) begin : g_live
      localparam logic [VC_W-1:0] VID = VC_W'(v);
      flit_vc_state #(.CNT_W(CNT_W)) u_vc (
        .clk       (clk),
        .rst       (rst),
        .hit       (xfer && in_vc == VID),
        .id        (in_id),
        .req       (in_req),
        .hdr_fmt   (hdr_fmt),
        .hdr_total (hdr_total),
        .sop       (vc_sop[v]),
        .eop       (vc_eop[v]),
        .err_seq   (vc_err_seq[v]),
        .fmt       (vc_fmt[v]),
        .cnt       (pkt_cnt[v*CNT_W +: CNT_W])
      );
    end else begin : g_pad
      // Unreachable VC codes when NUM_VCS is not a power of two.
      assign vc_sop[v]     = 1'b0;
      assign vc_eop[v]     = 1'b0;
      assign vc_err_seq[v] = 1'b0;
      assign vc_fmt[v]     = 4'd0;
    end
  end

  out_flit_t out_d, out_q;

  always_comb begin
    out_d         = '0;
    out_d.vc      = in_vc;
    out_d.id      = in_id;
    out_d.req     = in_req;
    out_d.payload = in_payload;
    out_d.sop     = vc_sop[in_vc];
    out_d.eop     = vc_eop[in_vc];
    out_d.fmt     = vc_fmt[in_vc];
    out_d.err_fmt = vc_sop[in_vc] && (hdr_fmt >= 4'd7);
    out_d.err_seq = vc_err_seq[in_vc];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_q     <= out_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_vc      = out_q.vc;
  assign out_id      = out_q.id;
  assign out_req     = out_q.req;
  assign out_payload = out_q.payload;
  assign out_sop     = out_q.sop;
  assign out_eop     = out_q.eop;
  assign out_fmt     = out_q.fmt;
  assign err_fmt     = out_q.err_fmt;
  assign err_seq     = out_q.err_seq;
endmodule

// File: tb/tb_flit_pkt_tracker.sv
// Directed bench for flit_pkt_tracker: vector table plus long-packet, backpressure
// and mid-packet reset sequences.

module tb_flit_pkt_tracker;
  localparam int NUM_VCS = 2;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 16;
  localparam int VC_W    = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid, in_ready;
  logic [VC_W-1:0]          in_vc;
  logic [1:0]               in_id;
  logic [4:0]               in_req;
  logic [WORD_W-1:0]        in_payload;
  logic                     out_valid, out_ready;
  logic [VC_W-1:0]          out_vc;
  logic [1:0]               out_id;
  logic [4:0]               out_req;
  logic [WORD_W-1:0]        out_payload;
  logic                     out_sop, out_eop, err_fmt, err_seq;
  logic [3:0]               out_fmt;
  logic [NUM_VCS*CNT_W-1:0] pkt_cnt;

  flit_pkt_tracker #(.NUM_VCS(NUM_VCS), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vc(in_vc), .in_id(in_id),
    .in_req(in_req), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc), .out_id(out_id),
    .out_req(out_req), .out_payload(out_payload), .out_sop(out_sop), .out_eop(out_eop),
    .out_fmt(out_fmt), .err_fmt(err_fmt), .err_seq(err_seq), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vc;
    logic [1:0]  id;
    logic [4:0]  req;
    logic [31:0] pay;
    logic        sop;
    logic        eop;
    logic [3:0]  fmt;
    logic        ef;
    logic        es;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   exp_cnt [NUM_VCS];
  vec_t tv [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vc, input logic [1:0] id, input logic [4:0] req,
                       input logic [31:0] pay);
    in_valid   = 1'b1;
    in_vc      = vc;
    in_id      = id;
    in_req     = req;
    in_payload = pay;
  endtask

  function automatic vec_t mk(input logic vc, input logic [1:0] id, input logic [4:0] req,
                              input logic [31:0] pay, input logic sop, input logic eop,
                              input logic [3:0] fmt, input logic ef, input logic es);
    vec_t v;
    v.vc = vc; v.id = id; v.req = req; v.pay = pay;
    v.sop = sop; v.eop = eop; v.fmt = fmt; v.ef = ef; v.es = es;
    return v;
  endfunction

  task automatic check_cnt(input string name);
    chk({name, ".cnt0"}, 64'(pkt_cnt[0 +: CNT_W]), 64'(exp_cnt[0]));
    chk({name, ".cnt1"}, 64'(pkt_cnt[CNT_W +: CNT_W]), 64'(exp_cnt[1]));
  endtask

  // Sends one whole packet back-to-back; sop only on flit 0, eop only on the last.
  task automatic run_pkt(input string name, input logic vc, input logic [31:0] hdr, input int n);
    for (int i = 0; i < n; i++) begin
      drive(vc, 2'd1, 5'd7, (i == 0) ? hdr : (32'hB000_0000 | 32'(i)));
      step();
      chk($sformatf("%s[%0d].sop", name, i), 64'(out_sop), 64'(i == 0));
      chk($sformatf("%s[%0d].eop", name, i), 64'(out_eop), 64'(i == n - 1));
      if (i == n - 1) chk($sformatf("%s.fmt", name), 64'(out_fmt), 64'(hdr[31:28]));
    end
    in_valid = 1'b0;
    exp_cnt[vc]++;
  endtask

  initial begin
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    rst = 1'b1; in_valid = 1'b0; in_vc = '0; in_id = '0; in_req = '0; in_payload = '0;
    out_ready = 1'b1;

    //             vc id req  payload         sop eop fmt ef es
    // short write len 3 on VC0
    tv[0]  = mk(0, 0, 5, 32'h6180_0003, 1, 0, 6, 0, 0);
    tv[1]  = mk(0, 0, 5, 32'hF000_0001, 0, 0, 6, 0, 0);
    tv[2]  = mk(0, 0, 5, 32'h0000_0002, 0, 0, 6, 0, 0);
    tv[3]  = mk(0, 0, 5, 32'h4000_0003, 0, 1, 6, 0, 0);
    // VC0 msg len 2 interleaved with VC1 switch_cfg
    tv[4]  = mk(0, 0, 5, 32'h3000_0002, 1, 0, 3, 0, 0);
    tv[5]  = mk(1, 3, 9, 32'h4000_0000, 1, 1, 4, 0, 0);
    tv[6]  = mk(0, 0, 5, 32'h9000_0011, 0, 0, 3, 0, 0);
    tv[7]  = mk(1, 3, 9, 32'h4000_0000, 1, 1, 4, 0, 0);
    tv[8]  = mk(0, 0, 5, 32'h0000_0022, 0, 1, 3, 0, 0);
    // reserved format then short read on the same VC
    tv[9]  = mk(0, 1, 2, 32'h9000_0005, 1, 1, 9, 1, 0);
    tv[10] = mk(0, 1, 2, 32'h5000_0003, 1, 1, 5, 0, 0);
    // mem resp len 2 on VC1 with id glitch on the first body flit
    tv[11] = mk(1, 1, 4, 32'h2000_0002, 1, 0, 2, 0, 0);
    tv[12] = mk(1, 2, 4, 32'hC0DE_0001, 0, 0, 2, 0, 1);
    tv[13] = mk(1, 1, 4, 32'hC0DE_0002, 0, 1, 2, 0, 0);
    // long read on VC1: two flits regardless of length field
    tv[14] = mk(1, 0, 6, 32'h0000_0005, 1, 0, 0, 0, 0);
    tv[15] = mk(1, 0, 6, 32'h7777_0000, 0, 1, 0, 0, 0);

    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.flags", 64'({out_sop, out_eop, err_fmt, err_seq}), 64'd0);
    chk("rst.payload", 64'(out_payload), 64'd0);
    chk("rst.pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;

    foreach (tv[k]) begin
      chk($sformatf("v%0d.in_ready", k), 64'(in_ready), 64'd1);
      drive(tv[k].vc, tv[k].id, tv[k].req, tv[k].pay);
      step();
      chk($sformatf("v%0d.valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d.data", k), 64'({out_vc, out_id, out_req, out_payload}),
          64'({tv[k].vc, tv[k].id, tv[k].req, tv[k].pay}));
      chk($sformatf("v%0d.sop", k), 64'(out_sop), 64'(tv[k].sop));
      chk($sformatf("v%0d.eop", k), 64'(out_eop), 64'(tv[k].eop));
      chk($sformatf("v%0d.fmt", k), 64'(out_fmt), 64'(tv[k].fmt));
      chk($sformatf("v%0d.err_fmt", k), 64'(err_fmt), 64'(tv[k].ef));
      chk($sformatf("v%0d.err_seq", k), 64'(err_seq), 64'(tv[k].es));
      if (tv[k].eop) exp_cnt[tv[k].vc]++;
    end
    in_valid = 1'b0;
    step();
    chk("idle.out_valid", 64'(out_valid), 64'd0);
    check_cnt("table");

    // length 0 means 128 for 7-bit formats and 16 for 4-bit; upper bits must be ignored
    run_pkt("lwr", 1'b1, 32'h1000_0080, 130);
    run_pkt("swr", 1'b0, 32'h6000_0010, 17);
    step();
    check_cnt("long");

    // backpressure mid-packet: short write len 3 on VC0
    drive(0, 2'd0, 5'd3, 32'h6000_0003); step();
    drive(0, 2'd0, 5'd3, 32'hAAAA_0001); step();
    out_ready = 1'b0;
    drive(0, 2'd0, 5'd3, 32'hAAAA_0002);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d.hold", c), 64'({out_valid, out_sop, out_eop, out_payload}),
          64'({1'b1, 1'b0, 1'b0, 32'hAAAA_0001}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp.next", 64'({out_valid, out_sop, out_eop, out_payload}),
        64'({1'b1, 1'b0, 1'b0, 32'hAAAA_0002}));

    // asynchronous reset with one flit of the packet still outstanding
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.data", 64'({out_sop, out_eop, err_fmt, err_seq, out_fmt, out_payload}), 64'd0);
    chk("mrst.pkt_cnt", 64'(pkt_cnt), 64'd0);
    step();
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    drive(0, 2'd0, 5'd3, 32'h5000_0000);
    step();
    in_valid = 1'b0;
    chk("mrst.sop", 64'(out_sop), 64'd1);
    chk("mrst.eop", 64'(out_eop), 64'd1);
    chk("mrst.fmt", 64'(out_fmt), 64'd5);
    exp_cnt[0]++;
    step();
    check_cnt("mrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
